// File: rtl/spi_frame_tx_if.sv
// Signal bundle between the SPI frame transmitter and the logic that uses it.
// master: the transmitter itself (drives the SPI pins and status).
// slave : the host/peer side (drives start, tx_data and the returned sdi).
interface spi_frame_tx_if #(
    parameter int FRAME_BITS = 128
);
    logic                  start;
    logic [FRAME_BITS-1:0] tx_data;
    logic                  sdi;
    logic                  sck;
    logic                  sdo;
    logic                  load;
    logic                  busy;
    logic                  done;
    logic [FRAME_BITS-1:0] rx_data;

    modport master (
        input  start, tx_data, sdi,
        output sck, sdo, load, busy, done, rx_data
    );

    modport slave (
        output start, tx_data, sdi,
        input  sck, sdo, load, busy, done, rx_data
    );
endinterface

// File: rtl/spi_frame_tx.sv
// SPI mode-0 master: sends one FRAME_BITS frame MSB first on sck/sdo, framed
// by an active-high load strobe, and captures the full-duplex return on sdi.
//
// state | meaning
// IDLE  | waiting for start; sck=0, load=0, busy=0
// SETUP | load high, first bit on sdo, sck held low for CLK_DIV cycles
// SHIFT | sck toggles every CLK_DIV cycles; sdi sampled on rise, sdo moved on fall
// HOLD  | sck low, load still high for CLK_DIV cycles after the last fall
// GAP   | load low, busy high for GAP_CYCLES before the next frame may start
module spi_frame_tx #(
    parameter int FRAME_BITS = 128,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input logic            clk,
    input logic            reset_n,
    spi_frame_tx_if.master bus
);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic                  sck_q;
    logic                  sdo_q;
    logic                  load_q;
    logic                  busy_q;
    logic                  done_q;
    logic [FRAME_BITS-1:0] rx_data_q;
    logic                  accept;

    // A frame starts from IDLE, or straight out of the last gap cycle when start
    // is held, so back-to-back frames keep load low for exactly GAP_CYCLES.
    always_comb begin
        accept = 1'b0;
        if (bus.start) begin
            if (state == IDLE) begin
                accept = 1'b1;
            end else if (state == GAP && cnt == GAP_LAST) begin
                accept = 1'b1;
            end
        end
    end

    // Frame sequencer; the divider counter restarts on every state change so each
    // sck half-period is a full CLK_DIV cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            sck_q     <= 1'b0;
            sdo_q     <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state   <= SETUP;
                cnt     <= '0;
                bit_cnt <= '0;
                tx_sr   <= bus.tx_data;
                rx_sr   <= '0;
                sdo_q   <= bus.tx_data[FRAME_BITS-1];
                sck_q   <= 1'b0;
                load_q  <= 1'b1;
                busy_q  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                    end
                    SETUP: begin
                        if (cnt == DIV_LAST) begin
                            cnt   <= '0;
                            sck_q <= 1'b1;
                            rx_sr <= {rx_sr[FRAME_BITS-2:0], bus.sdi};
                            state <= SHIFT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (cnt == DIV_LAST) begin
                            cnt <= '0;
                            if (sck_q) begin
                                sck_q <= 1'b0;
                                if (bit_cnt == BIT_LAST) begin
                                    // last bit stays on sdo; no further shift
                                    state <= HOLD;
                                end else begin
                                    tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                                    sdo_q   <= tx_sr[FRAME_BITS-2];
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end else begin
                                sck_q <= 1'b1;
                                rx_sr <= {rx_sr[FRAME_BITS-2:0], bus.sdi};
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt == DIV_LAST) begin
                            cnt       <= '0;
                            load_q    <= 1'b0;
                            done_q    <= 1'b1;
                            rx_data_q <= rx_sr;
                            state     <= GAP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == GAP_LAST) begin
                            cnt    <= '0;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sck     = sck_q;
    assign bus.sdo     = sdo_q;
    assign bus.load    = load_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule
